writeback_arbiter: RTL and testbench

WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

---
 rtl/writeback_arbiter.sv | 160 ++++++++++++++++
 tb/tb_writeback_arbiter.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/writeback_arbiter.sv
// writeback_arbiter: collects results from NUM_CH producer channels into
// per-channel FIFOs, then drains them round-robin, one entry per cycle, into
// a single registered register-file write port.
//
// Ports:
//   clk, reset           clock (rising edge), async active-low reset
//   enable               pops allowed when high
//   flush                synchronous discard of all buffered entries
//   in_valid/in_ready    per-channel handshake (NUM_CH bits each)
//   in_special           per-channel special-destination flag
//   in_dest, in_result   per-channel key/data, channel i at [i*W +: W]
//   portD_enable/key/value  registered register-file write port
//   busy                 some FIFO holds an entry
//   drop_count           saturating count of popped-but-discarded entries

module wb_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         empty,
    output logic         full
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    // Pointers carry one extra wrap bit to tell full from empty.
    logic [AW:0]  wptr, rptr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr <= '0;
            rptr <= '0;
        end else if (flush) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) wptr <= wptr + (AW+1)'(1);
            if (pop)  rptr <= rptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem[wptr[AW-1:0]] <= wdata;
    end

    assign rdata = mem[rptr[AW-1:0]];
    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
endmodule

module writeback_arbiter #(
    parameter int NUM_CH     = 2,
    parameter int DATA_W     = 32,
    parameter int REG_AW     = 5,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     flush,
    input  logic [NUM_CH-1:0]        in_valid,
    output logic [NUM_CH-1:0]        in_ready,
    input  logic [NUM_CH-1:0]        in_special,
    input  logic [NUM_CH*REG_AW-1:0] in_dest,
    input  logic [NUM_CH*DATA_W-1:0] in_result,
    output logic                     portD_enable,
    output logic [REG_AW-1:0]        portD_key,
    output logic [DATA_W-1:0]        portD_value,
    output logic                     busy,
    output logic [15:0]              drop_count
);
    localparam int EW = 1 + REG_AW + DATA_W;
    localparam int PW = $clog2(NUM_CH);

    typedef struct packed {
        logic              special;
        logic [REG_AW-1:0] dest;
        logic [DATA_W-1:0] result;
    } entry_t;

    entry_t [NUM_CH-1:0] wr_e, head;
    logic   [NUM_CH-1:0] empty, full, push, pop;
    logic   [PW-1:0]     rr_ptr, grant, rr_next;
    logic                found, do_pop, writable;
    entry_t              sel;
    int                  idx;

    genvar i;
    generate
        for (i = 0; i < NUM_CH; i++) begin : g_ch
            assign wr_e[i].special = in_special[i];
            assign wr_e[i].dest    = in_dest[i*REG_AW +: REG_AW];
            assign wr_e[i].result  = in_result[i*DATA_W +: DATA_W];
            assign push[i]         = in_valid[i] && !full[i] && !flush;
            assign pop[i]          = do_pop && (grant == PW'(i));

            wb_fifo #(.W(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
                .clk   (clk),
                .reset (reset),
                .push  (push[i]),
                .pop   (pop[i]),
                .flush (flush),
                .wdata (wr_e[i]),
                .rdata (head[i]),
                .empty (empty[i]),
                .full  (full[i])
            );
        end
    endgenerate

    assign in_ready = ~full;
    assign busy     = ~&empty;

    // Round-robin: first non-empty channel at or after rr_ptr, wrapping.
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < NUM_CH; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            if (!found && !empty[idx]) begin
                found = 1'b1;
                grant = PW'(idx);
            end
        end
    end

    assign do_pop   = enable && !flush && found;
    assign sel      = head[grant];
    // Special entries target key 0 only; ordinary entries never write key 0.
    assign writable = sel.special ? (sel.dest == '0) : (sel.dest != '0);
    assign rr_next  = (int'(grant) == NUM_CH-1) ? '0 : grant + PW'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr       <= '0;
            portD_enable <= 1'b0;
            portD_key    <= '0;
            portD_value  <= '0;
            drop_count   <= '0;
        end else begin
            portD_enable <= do_pop && writable;
            if (do_pop) begin
                rr_ptr      <= rr_next;
                portD_key   <= sel.dest;
                portD_value <= sel.result;
                if (!writable && drop_count != 16'hFFFF)
                    drop_count <= drop_count + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_writeback_arbiter.sv
module tb_writeback_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        enable, flush;
    logic [1:0]  in_valid, in_ready, in_special;
    logic [9:0]  in_dest;
    logic [63:0] in_result;
    logic        portD_enable;
    logic [4:0]  portD_key;
    logic [31:0] portD_value;
    logic        busy;
    logic [15:0] drop_count;

    int checks = 0;
    int failures = 0;
    int write_cnt = 0;
    logic [36:0] sb [$];

    writeback_arbiter dut (
        .clk(clk), .reset(reset), .enable(enable), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_special(in_special),
        .in_dest(in_dest), .in_result(in_result),
        .portD_enable(portD_enable), .portD_key(portD_key),
        .portD_value(portD_value), .busy(busy), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic bit model_writable(input logic sp, input logic [4:0] d);
        return sp ? (d == 5'd0) : (d != 5'd0);
    endfunction

    task automatic push1(input int ch, input logic sp, input logic [4:0] d,
                         input logic [31:0] r, input bit track);
        in_valid[ch]          = 1'b1;
        in_special[ch]        = sp;
        in_dest[ch*5 +: 5]    = d;
        in_result[ch*32 +: 32] = r;
        if (track && model_writable(sp, d)) sb.push_back({d, r});
        step();
        in_valid[ch] = 1'b0;
    endtask

    // Scoreboard: every observed write must match the oldest expected one.
    always @(negedge clk) begin
        if (reset === 1'b1 && portD_enable === 1'b1) begin
            write_cnt++;
            if (sb.size() == 0) chk("unexpected_write", {63'd0, portD_enable}, 64'd0);
            else chk("write_key_value", {27'd0, portD_key, portD_value}, {27'd0, sb.pop_front()});
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int wc;
        logic [15:0] dc;
        reset = 1'b0; enable = 1'b0; flush = 1'b0;
        in_valid = '0; in_special = '0; in_dest = '0; in_result = '0;
        #3;
        chk("rst_in_ready", {62'd0, in_ready}, 64'h3);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_portD_enable", {63'd0, portD_enable}, 64'd0);
        chk("rst_drop_count", {48'd0, drop_count}, 64'd0);
        step(); step();
        reset = 1'b1;

        // Single push, two-edge latency.
        enable = 1'b1;
        push1(0, 1'b0, 5'd5, 32'hDEADBEEF, 1'b1);
        chk("single_busy_queued", {63'd0, busy}, 64'd1);
        step();
        chk("single_enable", {63'd0, portD_enable}, 64'd1);
        chk("single_key", {59'd0, portD_key}, 64'd5);
        chk("single_busy_after", {63'd0, busy}, 64'd0);
        step();
        chk("single_enable_drop", {63'd0, portD_enable}, 64'd0);
        chk("single_key_hold", {59'd0, portD_key}, 64'd5);

        // Filter rule.
        wc = write_cnt;
        push1(0, 1'b0, 5'd0, 32'hAAAA0000, 1'b1);
        push1(0, 1'b1, 5'd3, 32'hBBBB0000, 1'b1);
        push1(0, 1'b1, 5'd0, 32'h00001234, 1'b1);
        step(); step(); step();
        chk("filter_drops", {48'd0, drop_count}, 64'd2);
        chk("filter_writes", 64'(write_cnt - wc), 64'd1);
        chk("filter_value_hold", {32'd0, portD_value}, 64'h1234);

        // Fairness: rr_ptr is 1 after ch0-only grants, so ch1 goes first.
        enable = 1'b0;
        for (int k = 0; k < 4; k++) begin
            in_valid = 2'b11; in_special = 2'b00;
            in_dest = {5'(k + 9), 5'(k + 1)};
            in_result = {32'hC1000000 + 32'(k), 32'hC0000000 + 32'(k)};
            sb.push_back({5'(k + 9), 32'hC1000000 + 32'(k)});
            sb.push_back({5'(k + 1), 32'hC0000000 + 32'(k)});
            step();
        end
        in_valid = '0;
        chk("fair_full", {62'd0, in_ready}, 64'd0);
        wc = write_cnt;
        enable = 1'b1;
        repeat (8) step();
        @(negedge clk); #1;
        chk("fair_8_writes", 64'(write_cnt - wc), 64'd8);
        chk("fair_busy_done", {63'd0, busy}, 64'd0);

        // Backpressure on ch1.
        enable = 1'b0;
        for (int k = 0; k < 5; k++) begin
            in_valid[1] = 1'b1; in_special[1] = 1'b0;
            in_dest[9:5] = 5'(k + 1);
            in_result[63:32] = 32'hB0000000 + 32'(k);
            chk("bp_in_ready", {63'd0, in_ready[1]}, (k < 4) ? 64'd1 : 64'd0);
            if (k < 4) sb.push_back({5'(k + 1), 32'hB0000000 + 32'(k)});
            step();
        end
        in_valid = '0;
        chk("bp_no_write", {63'd0, portD_enable}, 64'd0);
        wc = write_cnt;
        enable = 1'b1;
        step();
        chk("bp_ready_freed", {63'd0, in_ready[1]}, 64'd1);
        repeat (3) step();
        @(negedge clk); #1;
        chk("bp_4_writes", 64'(write_cnt - wc), 64'd4);

        // Flush with 3 queued entries, one of which would be a drop.
        enable = 1'b0;
        push1(0, 1'b0, 5'd0, 32'hF0, 1'b0);
        push1(0, 1'b0, 5'd6, 32'hF1, 1'b0);
        push1(0, 1'b0, 5'd7, 32'hF2, 1'b0);
        chk("flush_busy_before", {63'd0, busy}, 64'd1);
        dc = drop_count; wc = write_cnt;
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_busy_after", {63'd0, busy}, 64'd0);
        enable = 1'b1;
        repeat (3) step();
        chk("flush_no_write", 64'(write_cnt - wc), 64'd0);
        chk("flush_drop_same", {48'd0, drop_count}, {48'd0, dc});

        // Reset between push and write.
        push1(0, 1'b0, 5'd9, 32'h77, 1'b0);
        wc = write_cnt;
        reset = 1'b0;
        #1;
        chk("rst2_enable", {63'd0, portD_enable}, 64'd0);
        chk("rst2_key", {59'd0, portD_key}, 64'd0);
        chk("rst2_value", {32'd0, portD_value}, 64'd0);
        chk("rst2_drop", {48'd0, drop_count}, 64'd0);
        chk("rst2_busy", {63'd0, busy}, 64'd0);
        chk("rst2_in_ready", {62'd0, in_ready}, 64'h3);
        step(); step();
        reset = 1'b1;
        repeat (3) step();
        chk("rst2_no_write", 64'(write_cnt - wc), 64'd0);
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
